// File: rtl/wb_mem_stage.sv
// MEM/WB segment register with an integrated dual-port data RAM, lane-steered
// stores, extended loads and a latency FSM. Define WB_MEM_STAT_EN for counters.
module wb_mem_stage #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clear,
  input  logic [XLEN-1:0] AM,
  input  logic [XLEN-1:0] WDM,
  input  logic [2:0]      MemOpM,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  output logic            MemBusy,
  output logic            MisalignM,
  output logic [XLEN-1:0] RD,
  output logic            MisalignW,
  input  logic [XLEN-1:0] A2,
  input  logic [XLEN-1:0] WD2,
  input  logic [3:0]      WE2,
  output logic [XLEN-1:0] RD2,
  input  logic [XLEN-1:0] ResultM,
  output logic [XLEN-1:0] ResultW,
  input  logic [4:0]      RdM,
  output logic [4:0]      RdW,
  input  logic [2:0]      RegWriteM,
  output logic [2:0]      RegWriteW,
  input  logic            MemToRegM,
  output logic            MemToRegW
`ifdef WB_MEM_STAT_EN
  ,
  output logic [31:0]     StallCnt,
  output logic [31:0]     AccessCnt
`endif
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              req, access, is_half, is_word;
  logic              last_cycle, capture;
  logic [3:0]        lane_we, a_we;
  logic [XLEN-1:0]   a_wdata;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [XLEN-1:0]   mem [DEPTH];
  logic [XLEN-1:0]   raw_q, rd_last_q, ext;
  logic [1:0]        off_q;
  logic [2:0]        op_q;
  logic              en_q, clear_q;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              unused_bits;

  // Size decode: 00 byte, 01 half, 1x word (unsupported encodings fall to word).
  assign is_half   = (MemOpM[1:0] == 2'b01);
  assign is_word   = MemOpM[1];
  assign req       = MemReadM | MemWriteM;
  assign MisalignM = req & ((is_half & AM[0]) | (is_word & (AM[1:0] != 2'b00)));
  assign access    = req & ~MisalignM;

  assign addr_a  = AM[ADDR_W+1:2];
  assign addr_b  = A2[ADDR_W+1:2];
  assign capture = en & ~MemBusy;

  assign unused_bits = ^{AM[XLEN-1:ADDR_W+2], A2[XLEN-1:ADDR_W+2], A2[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    MemBusy    = 1'b0;
    last_cycle = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && !clear && !rst) begin
          if (MEM_LAT > 0) begin
            MemBusy = 1'b1;
            state_d = S_WAIT;
            cnt_d   = 3'(MEM_LAT - 1);
          end else begin
            last_cycle = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (clear) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != 3'd0) begin
          MemBusy = 1'b1;
          cnt_d   = cnt_q - 3'd1;
        end else begin
          last_cycle = access;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lane_we = 4'b1111;
    a_wdata = WDM;
    case (MemOpM[1:0])
      2'b00: begin
        lane_we = 4'b0001 << AM[1:0];
        a_wdata = {4{WDM[7:0]}};
      end
      2'b01: begin
        lane_we = AM[1] ? 4'b1100 : 4'b0011;
        a_wdata = {2{WDM[15:0]}};
      end
      default: ;
    endcase
  end

  // The store commits only on the access's final cycle, never while in reset.
  assign a_we = {4{MemWriteM & last_cycle & ~rst}} & lane_we;

  // NOTE: the RAM array carries no reset; only control and pipeline state are reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (WE2[i])  mem[addr_b][8*i +: 8] <= WD2[8*i +: 8];
      if (a_we[i]) mem[addr_a][8*i +: 8] <= a_wdata[8*i +: 8];
    end
    RD2 <= mem[addr_b];
    if (capture) raw_q <= mem[addr_a];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ResultW   <= '0;
      RdW       <= '0;
      RegWriteW <= '0;
      MemToRegW <= 1'b0;
      MisalignW <= 1'b0;
      off_q     <= '0;
      op_q      <= '0;
    end else if (capture) begin
      if (clear) begin
        ResultW   <= '0;
        RdW       <= '0;
        RegWriteW <= '0;
        MemToRegW <= 1'b0;
        MisalignW <= 1'b0;
        off_q     <= '0;
        op_q      <= '0;
      end else begin
        ResultW   <= ResultM;
        RdW       <= RdM;
        RegWriteW <= MisalignM ? 3'b000 : RegWriteM;
        MemToRegW <= MemToRegM;
        MisalignW <= MisalignM;
        off_q     <= AM[1:0];
        op_q      <= MemOpM;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q      <= 1'b0;
      clear_q   <= 1'b0;
      rd_last_q <= '0;
    end else begin
      en_q      <= en;
      clear_q   <= clear;
      rd_last_q <= RD;
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    byte_sel = raw_q[7:0];
      2'd1:    byte_sel = raw_q[15:8];
      2'd2:    byte_sel = raw_q[23:16];
      default: byte_sel = raw_q[31:24];
    endcase
    half_sel = off_q[1] ? raw_q[31:16] : raw_q[15:0];
    case (op_q[1:0])
      2'b00:   ext = op_q[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   ext = op_q[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ext = raw_q;
    endcase
    if (!en_q)        RD = rd_last_q;
    else if (clear_q) RD = '0;
    else              RD = ext;
  end

`ifdef WB_MEM_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCnt  <= '0;
      AccessCnt <= '0;
    end else begin
      if (MemBusy && (StallCnt != '1))     StallCnt  <= StallCnt + 32'd1;
      if (last_cycle && (AccessCnt != '1)) AccessCnt <= AccessCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_mem_stage.sv
// Self-checking bench for wb_mem_stage: instance 0 has MEM_LAT=0, instance 1 has MEM_LAT=3.
module tb_wb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i [2], en_i [2], clr_i [2], rd_m [2], wr_m [2], m2r_m [2];
  logic [31:0] am [2], wdm [2], a2 [2], wd2 [2], res_m [2];
  logic [2:0]  op_m [2], rw_m [2];
  logic [3:0]  we2 [2];
  logic [4:0]  rdst_m [2];

  logic        busy_o [2], mis_o [2], misw_o [2], m2r_w [2];
  logic [31:0] rd_o [2], rd2_o [2], res_w [2];
  logic [4:0]  rdst_w [2];
  logic [2:0]  rw_w [2];
`ifdef WB_MEM_STAT_EN
  logic [31:0] stall_o [2], acc_o [2];
`endif

  logic [7:0] mdl [2][128];
  int n_tests = 0;
  int n_fail  = 0;

  wb_mem_stage #(.XLEN(32), .ADDR_W(12), .MEM_LAT(0)) dut_l0 (
    .clk(clk), .rst(rst_i[0]), .en(en_i[0]), .clear(clr_i[0]),
    .AM(am[0]), .WDM(wdm[0]), .MemOpM(op_m[0]), .MemReadM(rd_m[0]), .MemWriteM(wr_m[0]),
    .MemBusy(busy_o[0]), .MisalignM(mis_o[0]), .RD(rd_o[0]), .MisalignW(misw_o[0]),
    .A2(a2[0]), .WD2(wd2[0]), .WE2(we2[0]), .RD2(rd2_o[0]),
    .ResultM(res_m[0]), .ResultW(res_w[0]), .RdM(rdst_m[0]), .RdW(rdst_w[0]),
    .RegWriteM(rw_m[0]), .RegWriteW(rw_w[0]), .MemToRegM(m2r_m[0]), .MemToRegW(m2r_w[0])
`ifdef WB_MEM_STAT_EN
    , .StallCnt(stall_o[0]), .AccessCnt(acc_o[0])
`endif
  );

  wb_mem_stage #(.XLEN(32), .ADDR_W(12), .MEM_LAT(3)) dut_l3 (
    .clk(clk), .rst(rst_i[1]), .en(en_i[1]), .clear(clr_i[1]),
    .AM(am[1]), .WDM(wdm[1]), .MemOpM(op_m[1]), .MemReadM(rd_m[1]), .MemWriteM(wr_m[1]),
    .MemBusy(busy_o[1]), .MisalignM(mis_o[1]), .RD(rd_o[1]), .MisalignW(misw_o[1]),
    .A2(a2[1]), .WD2(wd2[1]), .WE2(we2[1]), .RD2(rd2_o[1]),
    .ResultM(res_m[1]), .ResultW(res_w[1]), .RdM(rdst_m[1]), .RdW(rdst_w[1]),
    .RegWriteM(rw_m[1]), .RegWriteW(rw_w[1]), .MemToRegM(m2r_m[1]), .MemToRegW(m2r_w[1])
`ifdef WB_MEM_STAT_EN
    , .StallCnt(stall_o[1]), .AccessCnt(acc_o[1])
`endif
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs(input int d);
    en_i[d] = 1'b1;  clr_i[d] = 1'b0;  rd_m[d] = 1'b0;  wr_m[d] = 1'b0;
    am[d] = '0;      wdm[d] = '0;      op_m[d] = 3'd2;  m2r_m[d] = 1'b0;
    a2[d] = '0;      wd2[d] = '0;      we2[d] = 4'h0;
    res_m[d] = '0;   rdst_m[d] = '0;   rw_m[d] = '0;
  endtask

  task automatic read_b(input int d, input logic [31:0] addr, output logic [31:0] data);
    a2[d]  = addr;
    we2[d] = 4'h0;
    step();
    data = rd2_o[d];
  endtask

  // Presents one port-A access and holds it until the segment captures it.
  task automatic mem_access(input int d, input logic rd, input logic wr, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] res, input logic [4:0] rdst, input logic [2:0] rw,
                            input logic m2r, output int busy_n, output logic mis);
    logic b;
    logic tmo;
    en_i[d] = 1'b1; clr_i[d] = 1'b0;
    rd_m[d] = rd; wr_m[d] = wr; op_m[d] = op; am[d] = addr; wdm[d] = wdata;
    res_m[d] = res; rdst_m[d] = rdst; rw_m[d] = rw; m2r_m[d] = m2r;
    busy_n = 0; tmo = 1'b1; mis = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) mis = mis_o[d];
      b = busy_o[d];
      if (b) busy_n++;
      @(posedge clk);
      #1;
      if (!b) begin
        tmo = 1'b0;
        break;
      end
    end
    rd_m[d] = 1'b0;
    wr_m[d] = 1'b0;
    n_tests++;
    if (tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL access_timeout dut%0d addr=%h: busy never dropped within 16 cycles", d, addr);
    end
  endtask

  task automatic preload(input int d);
    logic [31:0] v;
    for (int w = 0; w < 32; w++) begin
      v = $urandom;
      a2[d] = 32'h200 + 32'(4 * w); wd2[d] = v; we2[d] = 4'hF;
      for (int i = 0; i < 4; i++) mdl[d][4*w+i] = 8'(v >> (8 * i));
      step();
    end
    we2[d] = 4'h0;
  endtask

  task automatic test_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      rst_i[d] = 1'b1; res_m[d] = 32'hFFFF_FFFF; rdst_m[d] = 5'h1F; rw_m[d] = 3'h7; m2r_m[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({res_w[d], rdst_w[d], rw_w[d], m2r_w[d], misw_o[d]} !== '0) begin
        n_fail++;
        $display("FAIL reset_wregs dut%0d: got res=%h rd=%h rw=%h m2r=%b mis=%b, want all 0",
                 d, res_w[d], rdst_w[d], rw_w[d], m2r_w[d], misw_o[d]);
      end
      n_tests++;
      if (rd_o[d] !== 32'h0) begin n_fail++; $display("FAIL reset_rd dut%0d: got %h want 0", d, rd_o[d]); end
      n_tests++;
      if (busy_o[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b want 0", d, busy_o[d]); end
`ifdef WB_MEM_STAT_EN
      n_tests++;
      if ({stall_o[d], acc_o[d]} !== 64'h0) begin
        n_fail++; $display("FAIL reset_stats dut%0d: got %h/%h want 0", d, stall_o[d], acc_o[d]);
      end
`endif
    end
    for (int d = 0; d < 2; d++) begin idle_inputs(d); rst_i[d] = 1'b0; end
    step();
  endtask

  task automatic test_store_load();
    logic [2:0]  ops  [7] = '{3'd0, 3'd1, 3'd0, 3'd4, 3'd2, 3'd5, 3'd1};
    logic [31:0] adrs [7] = '{32'h13, 32'h12, 32'h21, 32'h21, 32'h20, 32'h22, 32'h20};
    logic [31:0] exps [7] = '{32'h11, 32'h1122, 32'hFFFF_FF80, 32'h80, 32'hAABB_80DD,
                              32'h0000_AABB, 32'hFFFF_80DD};
    int bn; logic mis;
    mem_access(0, 0, 1, 3'd2, 32'h10, 32'h1122_3344, 0, 0, 0, 0, bn, mis);
    n_tests++;
    if (bn != 0) begin n_fail++; $display("FAIL sw_busy_lat0: got %0d busy cycles want 0", bn); end
    mem_access(0, 0, 1, 3'd2, 32'h20, 32'hAABB_CCDD, 0, 0, 0, 0, bn, mis);
    mem_access(0, 0, 1, 3'd0, 32'h21, 32'h0000_0080, 0, 0, 0, 0, bn, mis);
    for (int i = 0; i < 7; i++) begin
      mem_access(0, 1, 0, ops[i], adrs[i], 0, 0, 0, 3'd1, 1, bn, mis);
      n_tests++;
      if (rd_o[0] !== exps[i]) begin
        n_fail++;
        $display("FAIL load_extend[%0d] op=%0d addr=%h: got %h want %h", i, ops[i], adrs[i], rd_o[0], exps[i]);
      end
    end
  endtask

  task automatic test_misalign();
    int bn; logic mis; logic [31:0] v;
    mem_access(0, 1, 0, 3'd1, 32'h11, 0, 32'h55, 5'd7, 3'd1, 1, bn, mis);
    n_tests++;
    if (mis !== 1'b1) begin n_fail++; $display("FAIL misalign_lh_flag: got %b want 1", mis); end
    n_tests++;
    if (bn != 0) begin n_fail++; $display("FAIL misalign_busy: got %0d want 0", bn); end
    n_tests++;
    if ({rw_w[0], misw_o[0]} !== 4'b000_1) begin
      n_fail++; $display("FAIL misalign_capture: got rw=%h misw=%b want rw=0 misw=1", rw_w[0], misw_o[0]);
    end
    mem_access(0, 0, 1, 3'd2, 32'h12, 32'hFFFF_FFFF, 0, 0, 3'd1, 0, bn, mis);
    read_b(0, 32'h10, v);
    n_tests++;
    if (v !== 32'h1122_3344) begin n_fail++; $display("FAIL misalign_no_write: got %h want 11223344", v); end
    mem_access(0, 1, 0, 3'd2, 32'h10, 0, 0, 0, 3'd1, 0, bn, mis);
    n_tests++;
    if ({rw_w[0], misw_o[0]} !== 4'b001_0) begin
      n_fail++; $display("FAIL aligned_after_misalign: got rw=%h misw=%b want rw=1 misw=0", rw_w[0], misw_o[0]);
    end
  endtask

  task automatic test_hold_flush();
    int bn; logic mis;
    mem_access(0, 0, 1, 3'd2, 32'h30, 32'hCAFE_F00D, 0, 0, 0, 0, bn, mis);
    mem_access(0, 1, 0, 3'd2, 32'h30, 0, 0, 0, 3'd1, 1, bn, mis);
    n_tests++;
    if (rd_o[0] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL hold_load: got %h want cafef00d", rd_o[0]); end
    en_i[0] = 1'b0; rd_m[0] = 1'b1; am[0] = 32'h10; op_m[0] = 3'd2; rw_m[0] = 3'd5;
    for (int c = 0; c < 2; c++) begin
      step();
      n_tests++;
      if (rd_o[0] !== 32'hCAFE_F00D) begin
        n_fail++; $display("FAIL hold_stall[%0d]: got %h want cafef00d", c, rd_o[0]);
      end
    end
    en_i[0] = 1'b1; clr_i[0] = 1'b1;
    step();
    n_tests++;
    if ({rd_o[0], rw_w[0]} !== 35'h0) begin
      n_fail++; $display("FAIL flush_rd: got rd=%h rw=%h want 0", rd_o[0], rw_w[0]);
    end
    idle_inputs(0);
    step();
  endtask

  task automatic test_port_collision();
    int bn; logic mis; logic [31:0] v;
    a2[0] = 32'h08; wd2[0] = 32'h5A5A_9999; we2[0] = 4'hF;
    mem_access(0, 0, 1, 3'd2, 32'h08, 32'hA5A5_1234, 0, 0, 0, 0, bn, mis);
    read_b(0, 32'h08, v);
    n_tests++;
    if (v !== 32'hA5A5_1234) begin n_fail++; $display("FAIL collide_word: got %h want a5a51234", v); end
    a2[0] = 32'h08; wd2[0] = 32'h1111_1111; we2[0] = 4'hF;
    mem_access(0, 0, 1, 3'd0, 32'h09, 32'h0000_0077, 0, 0, 0, 0, bn, mis);
    read_b(0, 32'h08, v);
    n_tests++;
    if (v !== 32'h1111_7711) begin n_fail++; $display("FAIL collide_lane: got %h want 11117711", v); end
  endtask

  task automatic test_latency();
    int bn; logic mis;
`ifdef WB_MEM_STAT_EN
    logic [31:0] s0, a0;
`endif
    mem_access(1, 0, 1, 3'd2, 32'h10, 32'h1122_3344, 0, 0, 0, 0, bn, mis);
    n_tests++;
    if (bn != 3) begin n_fail++; $display("FAIL sw_busy_lat3: got %0d busy cycles want 3", bn); end
`ifdef WB_MEM_STAT_EN
    s0 = stall_o[1]; a0 = acc_o[1];
`endif
    rd_m[1] = 1'b1; op_m[1] = 3'd2; am[1] = 32'h10; en_i[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (busy_o[1] !== (k < 3)) begin
        n_fail++; $display("FAIL lat3_busy_cycle%0d: got %b want %b", k, busy_o[1], k < 3);
      end
      @(posedge clk);
      #1;
    end
    rd_m[1] = 1'b0;
    n_tests++;
    if (rd_o[1] !== 32'h1122_3344) begin n_fail++; $display("FAIL lat3_rd: got %h want 11223344", rd_o[1]); end
`ifdef WB_MEM_STAT_EN
    n_tests++;
    if (stall_o[1] - s0 !== 32'd3) begin n_fail++; $display("FAIL stallcnt_delta: got %0d want 3", stall_o[1] - s0); end
    n_tests++;
    if (acc_o[1] - a0 !== 32'd1) begin n_fail++; $display("FAIL accesscnt_delta: got %0d want 1", acc_o[1] - a0); end
`endif
  endtask

  task automatic test_clear_wait();
    logic [31:0] v;
    a2[1] = 32'h40; wd2[1] = 32'h0102_0304; we2[1] = 4'hF;
    step();
    we2[1] = 4'h0;
    wr_m[1] = 1'b1; op_m[1] = 3'd2; am[1] = 32'h40; wdm[1] = 32'hDEAD_BEEF;
    res_m[1] = 32'h1234_5678; rdst_m[1] = 5'd5; rw_m[1] = 3'd3; m2r_m[1] = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy_o[1] !== 1'b1) begin n_fail++; $display("FAIL clear_pre_busy: got %b want 1", busy_o[1]); end
    step();
    clr_i[1] = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy_o[1] !== 1'b0) begin n_fail++; $display("FAIL clear_busy_drop: got %b want 0", busy_o[1]); end
    step();
    clr_i[1] = 1'b0; wr_m[1] = 1'b0;
    n_tests++;
    if ({res_w[1], rdst_w[1], rw_w[1], m2r_w[1], rd_o[1]} !== '0) begin
      n_fail++;
      $display("FAIL clear_wregs: got res=%h rd=%h rw=%h m2r=%b RD=%h want all 0",
               res_w[1], rdst_w[1], rw_w[1], m2r_w[1], rd_o[1]);
    end
    step();
    read_b(1, 32'h40, v);
    n_tests++;
    if (v !== 32'h0102_0304) begin n_fail++; $display("FAIL clear_no_write: got %h want 01020304", v); end
  endtask

  task automatic test_reset_wait();
    logic [31:0] v;
    a2[1] = 32'h44; wd2[1] = 32'h0BAD_F00D; we2[1] = 4'hF;
    step();
    we2[1] = 4'h0;
    wr_m[1] = 1'b1; op_m[1] = 3'd2; am[1] = 32'h44; wdm[1] = 32'h5555_5555;
    step();
    #2 rst_i[1] = 1'b1;
    #1;
    n_tests++;
    if ({busy_o[1], rd_o[1]} !== 33'h0) begin
      n_fail++; $display("FAIL rst_in_wait: got busy=%b RD=%h want 0", busy_o[1], rd_o[1]);
    end
    wr_m[1] = 1'b0;
    step();
    rst_i[1] = 1'b0;
    step();
    read_b(1, 32'h44, v);
    n_tests++;
    if (v !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rst_no_write: got %h want 0badf00d", v); end
  endtask

  task automatic test_random(input int d, input int iters);
    logic [31:0] addr, wdata, res, exp_rd;
    logic [2:0]  op, rw;
    logic [4:0]  rdst;
    logic        m2r, is_st, mis, exp_mis, sgn;
    int          size, bn, off, exp_bn;
    preload(d);
    for (int it = 0; it < iters; it++) begin
      op    = 3'($urandom_range(0, 7));
      off   = $urandom_range(0, 127);
      addr  = 32'h200 + 32'(off);
      is_st = 1'($urandom_range(0, 1));
      wdata = $urandom; res = $urandom; rdst = 5'($urandom); rw = 3'($urandom); m2r = 1'($urandom);
      case (op)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        default:    size = 4;
      endcase
      sgn     = (op == 3'd0) || (op == 3'd1);
      exp_mis = (off % size) != 0;
      exp_bn  = exp_mis ? 0 : lat_of(d);
      exp_rd  = '0;
      if (!exp_mis) begin
        if (is_st) begin
          for (int i = 0; i < size; i++) mdl[d][off+i] = 8'(wdata >> (8 * i));
        end else begin
          for (int i = 0; i < size; i++) exp_rd = exp_rd | (32'(mdl[d][off+i]) << (8 * i));
          if (sgn && exp_rd[8*size-1]) exp_rd = exp_rd | ~((32'd1 << (8 * size)) - 32'd1);
        end
      end
      mem_access(d, !is_st, is_st, op, addr, wdata, res, rdst, rw, m2r, bn, mis);
      n_tests++;
      if ({mis, misw_o[d]} !== {exp_mis, exp_mis}) begin
        n_fail++; $display("FAIL rnd_misalign dut%0d it%0d: got M=%b W=%b want %b", d, it, mis, misw_o[d], exp_mis);
      end
      n_tests++;
      if (bn != exp_bn) begin
        n_fail++; $display("FAIL rnd_busy dut%0d it%0d: got %0d want %0d", d, it, bn, exp_bn);
      end
      n_tests++;
      if ({res_w[d], rdst_w[d], rw_w[d], m2r_w[d]} !== {res, rdst, (exp_mis ? 3'd0 : rw), m2r}) begin
        n_fail++;
        $display("FAIL rnd_passthru dut%0d it%0d: got %h/%h/%h/%b want %h/%h/%h/%b", d, it,
                 res_w[d], rdst_w[d], rw_w[d], m2r_w[d], res, rdst, (exp_mis ? 3'd0 : rw), m2r);
      end
      if (!is_st && !exp_mis) begin
        n_tests++;
        if (rd_o[d] !== exp_rd) begin
          n_fail++;
          $display("FAIL rnd_load dut%0d it%0d op=%0d addr=%h: got %h want %h", d, it, op, addr, rd_o[d], exp_rd);
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      idle_inputs(d);
      rst_i[d] = 1'b0;
    end
    test_reset();
    test_store_load();
    test_misalign();
    test_hold_flush();
    test_port_collision();
    test_random(0, 60);
    test_latency();
    test_clear_wait();
    test_reset_wait();
    test_random(1, 40);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_mem_stage.md
Name: wb_mem_stage

Overview:
Parametrised MEM/WB segment register with an integrated dual-port data RAM. It performs aligned and sub-word stores with lane steering, and sign- or zero-extends loads internally. It detects misaligned accesses. A configurable memory latency is modelled by an FSM that raises a stall request to the hazard unit. Port B is a debug port that bypasses the pipeline.

Parameters:
XLEN, 32, data width; must be 32 (lane logic assumes 4 byte lanes)
ADDR_W, 12, word-address bits; RAM depth = 2**ADDR_W words
MEM_LAT, 0, extra wait cycles per port-A access (0..7); 0 = single-cycle behaviour

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  segment enable (low = stall from hazard unit)
clear  in  1  segment flush
AM  in  XLEN  byte address of access
WDM  in  XLEN  store data, right-aligned
MemOpM  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
MemReadM  in  1  load request
MemWriteM  in  1  store request
MemBusy  out  1  stall request to hazard unit (combinational)
MisalignM  out  1  misaligned access detected (combinational)
RD  out  XLEN  extended load data, valid in W
MisalignW  out  1  registered misalign flag
A2  in  XLEN  debug byte address
WD2  in  XLEN  debug write data
WE2  in  4  debug per-lane write enable
RD2  out  XLEN  debug read data, 1-cycle latency
ResultM/ResultW  in/out  XLEN  ALU result pass-through
RdM/RdW  in/out  5  destination register
RegWriteM/RegWriteW  in/out  3  write-back control
MemToRegM/MemToRegW  in/out  1  load-select control

Behaviour:
- Reset (async): all W outputs 0, RD 0, MisalignW 0, FSM IDLE, wait counter 0, no RAM write.
- Access = (MemReadM | MemWriteM) & ~MisalignM.
- MisalignM: (MemOp H/HU & AM[0]) | (MemOp W & AM[1:0]!=0). A misaligned access writes nothing, never asserts MemBusy, forces RegWriteW=0 and MisalignW=1 at capture.
- Store lanes: B → WE=0001<<AM[1:0], data byte replicated ×4. H → WE=0011 or 1100 by AM[1], halfword replicated ×2. W → 1111.
- RAM word address = AM[ADDR_W+1:2]. Read is synchronous. Store is written exactly once, on the final cycle of the access.
- FSM states: IDLE, WAIT.
  - IDLE: if access & MEM_LAT>0 & ~clear → WAIT, cnt=MEM_LAT-1, MemBusy=1.
  - WAIT: MemBusy=1 while cnt!=0, cnt decrements. When cnt==0, MemBusy=0, the write commits, and the FSM returns to IDLE.
  - MEM_LAT=0: the FSM never leaves IDLE and MemBusy stays 0.
- Capture: W registers load on posedge when en & ~MemBusy. If clear, all W registers load 0.
- Load latency: RD is valid in the cycle after capture, MEM_LAT+1 cycles after the access is first presented.
- RD hold/flush: if the previous cycle had en=0, RD holds its last value. Else, if the previous cycle had clear=1, RD=0. Else RD = extended raw data using the registered byte offset and MemOp:
  - B: sign-extend the selected byte.
  - BU: zero-extend the selected byte.
  - H/HU: sign- or zero-extend the half selected by offset[1].
  - W: raw word.
- clear during WAIT aborts the access: FSM to IDLE, no write, MemBusy drops the same cycle.
- rst during WAIT: immediate IDLE, no write.
- Port B: independent of the FSM. If both ports write the same word in the same cycle, port A data wins on overlapping lanes.
- Unsupported MemOp (011, 11x) with a request: treated as W.

Optional Feature:
WB_MEM_STAT_EN:
- Defined: adds outputs StallCnt[31:0] (cycles with MemBusy=1) and AccessCnt[31:0] (completed port-A accesses). Both are cleared by rst, saturate at all-ones, and are not reset by clear.
- Undefined: ports and counters are absent.

Test Plan:
- MEM_LAT=0, SW 0x11223344 @0x10, then LB @0x13, next cycle → RD=0x00000011. LH @0x12 → RD=0x00001122.
- SB 0x80 @0x21, then LB @0x21 → RD=0xFFFFFF80; LBU @0x21 → RD=0x00000080. Other bytes of word 0x20 are unchanged.
- MEM_LAT=3, LW @0x10 presented at cycle t → MemBusy high for cycles t..t+2, RD=0x11223344 at t+4. StallCnt=3 with WB_MEM_STAT_EN.
- LH @0x11 → MisalignM=1, MemBusy=0, no write, RegWriteW=0, MisalignW=1.
- MEM_LAT=2, SW 0xDEADBEEF @0x40, then clear asserted in WAIT → MemBusy drops, word 0x40 is unchanged (read via port B), W outputs 0.
- Load then en=0 for 2 cycles → RD held. Then clear=1 → next RD=0. Port A and port B both writing word 0x8 with lanes 1111 → port A data read back.
